// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and the default bit period.
// The default bit period is common to the transmitter and the receiver so both agree on baud.
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 5209;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input; both flops reset to RST_VAL.
// Latency is 2 cycles. There is no backpressure: the output follows the input continuously.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver: samples each bit at mid-period, strobes good bytes and framing errors.
// Latency is HALF_BIT+9*CLKS_PER_BIT+1 cycles after rxd_s falls, plus 2 sync cycles; no backpressure.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic                      CLK_50M,
    input  logic                      reset,
    input  logic                      RS232_DCE_RXD,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    output logic                      rx_frame_err,
    output logic                      rx_busy,
    output logic [UART_DATA_BITS-1:0] LED
);

    localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_END = 16'(HALF_BIT - 1);
    localparam logic [2:0]  LAST_IDX = 3'(UART_DATA_BITS - 1);

    uart_state_t               state;
    logic [15:0]               cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic                      rxd_s;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_rxd_sync (
        .clk (CLK_50M),
        .rst (reset),
        .d   (RS232_DCE_RXD),
        .q   (rxd_s)
    );

    always_ff @(posedge CLK_50M or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 16'd0;
            bit_idx      <= 3'd0;
            shift        <= '0;
            rx_data      <= '0;
            LED          <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_busy      <= 1'b0;
        end else begin
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state   <= START;
                        cnt     <= 16'd0;
                        rx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_END) begin
                        cnt <= 16'd0;
                        // A start bit that is high again at its midpoint was only a glitch.
                        if (!rxd_s) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_END) begin
                        cnt            <= 16'd0;
                        shift[bit_idx] <= rxd_s;
                        if (bit_idx == LAST_IDX) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_END) begin
                        cnt <= 16'd0;
                        // Leaving at the stop midpoint gives half a bit to catch a back-to-back start.
                        if (rxd_s) begin
                            rx_data  <= shift;
                            LED      <= shift;
                            rx_valid <= 1'b1;
                            state    <= IDLE;
                            rx_busy  <= 1'b0;
                        end else begin
                            rx_frame_err <= 1'b1;
                            state        <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                WAIT_HIGH: begin
                    if (rxd_s) begin
                        state   <= IDLE;
                        cnt     <= 16'd0;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= 16'd0;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx with a short bit period: directed corner cases, a vector table and random frames.
module tb_uart_rx;

    localparam int CLKS = 16;
    localparam int LAT  = CLKS / 2 + 9 * CLKS + 1 + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;
    logic [7:0] led;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    int start_cyc = 0;
    int valid_cyc = 0;
    int n_valid = 0;
    int n_err   = 0;
    logic [8:0] ev_q[$];   // {is_error, rx_data at strobe}
    logic [8:0] exp_q[$];
    logic [7:0] last_good = 8'h00;

    uart_rx #(
        .CLKS_PER_BIT (CLKS)
    ) dut (
        .CLK_50M       (clk),
        .reset         (rst),
        .RS232_DCE_RXD (rxd),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_frame_err  (rx_frame_err),
        .rx_busy       (rx_busy),
        .LED           (led)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            failed = failed + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (rx_valid || rx_frame_err)) begin
            check("valid_err_exclusive", {31'd0, rx_valid & rx_frame_err}, 32'd0);
            if (rx_valid) begin
                n_valid   = n_valid + 1;
                valid_cyc = cyc;
                check("led_mirror", {24'd0, led}, {24'd0, rx_data});
                ev_q.push_back({1'b0, rx_data});
            end
            if (rx_frame_err) begin
                n_err = n_err + 1;
                ev_q.push_back({1'b1, rx_data});
            end
        end
    end

    task automatic send_bit(input logic b, input int ncyc);
        rxd = b;
        repeat (ncyc) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop, input int gap);
        start_cyc = cyc;
        send_bit(1'b0, CLKS);
        for (int i = 0; i < 8; i++) send_bit(data[i], CLKS);
        send_bit(stop, CLKS);
        rxd = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    // Reference: a frame with a high stop bit yields its byte; otherwise an error with rx_data held.
    task automatic model_frame(input logic [7:0] data, input logic stop);
        if (stop) begin
            last_good = data;
            exp_q.push_back({1'b0, data});
        end else begin
            exp_q.push_back({1'b1, last_good});
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        int         exp_valid;
        int         exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int v0, e0, base;
        logic [7:0] d;
        logic       s;
        int         g;

        vecs[0] = '{8'h5A, 1'b1, 2,  1, 0};
        vecs[1] = '{8'h80, 1'b1, 0,  1, 0};
        vecs[2] = '{8'h01, 1'b0, 16, 0, 1};
        vecs[3] = '{8'hC3, 1'b1, 5,  1, 0};
        vecs[4] = '{8'h7E, 1'b0, 20, 0, 1};
        vecs[5] = '{8'hFE, 1'b1, 1,  1, 0};

        // Reset and idle line
        repeat (3) @(negedge clk);
        #1;
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_led", {24'd0, led}, 32'd0);
        check("rst_strobes", {30'd0, rx_valid, rx_frame_err}, 32'd0);
        check("rst_busy", {31'd0, rx_busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (1000) @(negedge clk);
        check("idle_no_events", ev_q.size(), 32'd0);
        check("idle_busy", {31'd0, rx_busy}, 32'd0);

        // Single frame 0x41 with latency
        send_frame(8'h41, 1'b1, CLKS);
        last_good = 8'h41;
        check("f41_count", n_valid, 32'd1);
        check("f41_data", {24'd0, rx_data}, 32'h41);
        check("f41_led", {24'd0, led}, 32'h41);
        check("f41_latency", valid_cyc - start_cyc, LAT);

        // Back-to-back, zero idle gap
        base = ev_q.size();
        e0 = n_err;
        send_frame(8'hA5, 1'b1, 0);
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, CLKS);
        last_good = 8'hFF;
        check("b2b_count", ev_q.size() - base, 32'd3);
        if (ev_q.size() - base == 3) begin
            check("b2b_0", {23'd0, ev_q[base]},     {23'd0, 9'h0A5});
            check("b2b_1", {23'd0, ev_q[base + 1]}, {23'd0, 9'h000});
            check("b2b_2", {23'd0, ev_q[base + 2]}, {23'd0, 9'h0FF});
        end
        check("b2b_no_err", n_err - e0, 32'd0);

        // Short low glitch on idle line
        base = ev_q.size();
        send_bit(1'b0, 5);
        send_bit(1'b1, 2 * CLKS);
        check("glitch_no_event", ev_q.size() - base, 32'd0);
        check("glitch_busy", {31'd0, rx_busy}, 32'd0);
        check("glitch_data", {24'd0, rx_data}, {24'd0, last_good});

        // Bad stop bit then line held low
        e0 = n_err;
        v0 = n_valid;
        send_bit(1'b0, CLKS);
        for (int i = 0; i < 8; i++) send_bit(logic'((8'h3C >> i) & 8'h01), CLKS);
        send_bit(1'b0, CLKS + 100);
        check("ferr_count", n_err - e0, 32'd1);
        check("ferr_no_valid", n_valid - v0, 32'd0);
        check("ferr_data_held", {24'd0, rx_data}, {24'd0, last_good});
        check("ferr_busy_low_line", {31'd0, rx_busy}, 32'd1);
        send_bit(1'b1, 4);
        check("ferr_busy_released", {31'd0, rx_busy}, 32'd0);

        // Reset in the middle of data bit 4 of 0x55
        base = ev_q.size();
        send_bit(1'b0, CLKS);
        for (int i = 0; i < 4; i++) send_bit(logic'((8'h55 >> i) & 8'h01), CLKS);
        send_bit(1'b1, CLKS / 2);
        check("mid_busy", {31'd0, rx_busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_data", {24'd0, rx_data}, 32'd0);
        check("mid_rst_led", {24'd0, led}, 32'd0);
        check("mid_rst_busy", {31'd0, rx_busy}, 32'd0);
        check("mid_rst_strobes", {30'd0, rx_valid, rx_frame_err}, 32'd0);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        last_good = 8'h00;
        repeat (CLKS) @(negedge clk);
        check("mid_no_event", ev_q.size() - base, 32'd0);
        send_frame(8'h12, 1'b1, CLKS);
        last_good = 8'h12;
        check("after_rst_count", ev_q.size() - base, 32'd1);
        check("after_rst_data", {24'd0, rx_data}, 32'h12);

        // Vector table
        foreach (vecs[k]) begin
            v0 = n_valid;
            e0 = n_err;
            send_frame(vecs[k].data, vecs[k].stop, vecs[k].gap + CLKS);
            if (vecs[k].exp_valid != 0) last_good = vecs[k].data;
            check($sformatf("vec%0d_valid", k), n_valid - v0, vecs[k].exp_valid);
            check($sformatf("vec%0d_err", k), n_err - e0, vecs[k].exp_err);
            check($sformatf("vec%0d_data", k), {24'd0, rx_data}, {24'd0, last_good});
        end

        // Random frames against the reference model
        base = ev_q.size();
        exp_q.delete();
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom_range(0, 255));
            s = ($urandom_range(0, 7) != 0);
            g = s ? $urandom_range(0, 5) : CLKS + $urandom_range(0, 5);
            model_frame(d, s);
            send_frame(d, s, g);
        end
        repeat (2 * CLKS) @(negedge clk);
        check("rand_count", ev_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < ev_q.size(); i++)
            check($sformatf("rand_ev%0d", i), {23'd0, ev_q[base + i]}, {23'd0, exp_q[i]});

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
